pipelined_alu: RTL
==================

# pipelined_alu

Parametrised, handshaked successor to the combinational datapath ALU. It accepts one operation per transaction on a valid/ready input port and returns a registered result with zero/overflow flags on a valid/ready output port. It supports the eight base TSC function codes plus iterative multiply and variable-amount shifts, which are computed over multiple cycles by an internal FSM. It sits between the register-file read stage and writeback in the multi-cycle CPU.

## Interface
- `WIDTH`, default 16: operand/result width; power of two, at least 4.
- `SHAMT_W`, default `$clog2(WIDTH)`: shift-amount field width, taken from `data_2[SHAMT_W-1:0]`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `func`  in  6  function code.
- `data_1`  in  WIDTH  operand A.
- `data_2`  in  WIDTH  operand B or shift amount.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  consumer takes the result; transfer occurs when `out_valid && out_ready` at a rising edge.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`, registered with `result`.
- `overflow`  out  1  arithmetic overflow flag, registered with `result`.

## Operation
- Function codes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 ORR.
  - 4 NOT: ~A.
  - 5 TCP: ~A+1.
  - 6 SHL: A<<1.
  - 7 SHR: A>>1, logical.
  - 8 MUL: unsigned A×B, low WIDTH bits.
  - 9 SLLV: A << B[SHAMT_W-1:0].
  - 10 SRAV: arithmetic A >>> B[SHAMT_W-1:0].
  - 11–63: undefined; result 0, flags 0 except `zero`=1, completes as a single-cycle op.
- Operands and `func` are captured at the accept edge. Later input changes have no effect on an operation in flight.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - EXEC: iterating; `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1. `in_ready` = `out_ready`, which allows a back-to-back accept on the same edge as the output transfer.
- Transitions:
  - IDLE/DONE, on accept of a single-cycle op (0–7, undefined, or SLLV/SRAV with amount 0) → DONE, result registered at the accept edge.
  - On accept of MUL, or of SLLV/SRAV with amount n>0 → EXEC, with the iteration counter loaded (WIDTH or n).
  - EXEC: one step per edge; when the counter reaches 0 → DONE.
  - DONE with `out_ready`=1 and no new accept → IDLE.
  - DONE with `out_ready`=0: `result`/flags held stable; the new input is not accepted.
- MUL algorithm: shift-add. Each step examines one multiplier bit (LSB first) and conditionally adds the multiplicand into a 2·WIDTH accumulator.
- Variable-shift algorithm: one bit per step. SRAV replicates A's MSB.
- Overflow rules:
  - ADD/SUB: signed two's-complement overflow (operand signs equal/differ and result sign differs).
  - TCP: 1 iff A is the most negative value.
  - MUL: 1 iff the upper WIDTH bits of the product are nonzero.
  - All other ops: 0.
- Widths: all arithmetic is modulo 2^WIDTH; carries out are discarded apart from the overflow rule.

## Timing
- Reset, asynchronous: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `overflow`=0, counter=0.
- Reset asserted mid-EXEC or in DONE aborts the operation immediately; the result is lost and no `out_valid` pulse occurs.
- Latency, with accept at edge k:
  - Single-cycle ops: `out_valid` high after edge k.
  - MUL: `out_valid` high after edge k+WIDTH.
  - SLLV/SRAV by n: `out_valid` high after edge k+n.
- Throughput:
  - One single-cycle op per clock while `out_ready`=1.
  - Iterative ops block `in_ready` for their full EXEC duration.
- `in_ready` is combinational from state and `out_ready` only; it never depends on `in_valid`.
- `result`, `zero` and `overflow` change only at edges where DONE is entered.

## Test plan
- Reset then ADD 0x7FFF+0x0001, WIDTH=16, `out_ready`=1 → after 1 edge: `result`=0x8000, `overflow`=1, `zero`=0.
- SUB 0x1234−0x1234, followed back-to-back by TCP 0x8000 on the next edge → results 0x0000 with `zero`=1, then 0x8000 with `overflow`=1; `out_valid` high on two consecutive cycles.
- MUL 0x0003×0x0005 → `in_ready`=0 for 16 cycles; `out_valid` after edge k+16, `result`=0x000F, `overflow`=0. MUL 0x0100×0x0100 → `result`=0x0000, `overflow`=1, `zero`=1.
- SRAV 0x8000 by 3 → `out_valid` after edge k+3, `result`=0xF000. SLLV 0x0001 by 0 → `result`=0x0001 after edge k.
- Hold `out_ready`=0 for 5 cycles after ADD 2+3 → `result` stays 0x0005, `in_ready`=0 with `in_valid` asserted, no second accept. Release → transfer, then the pending op is accepted on the same edge.
- Assert `reset` at cycle 8 of a MUL → immediately `out_valid`=0, `result`=0, `in_ready`=1. The next ADD 1+1 returns 0x0002 normally.

Source files
------------

// File: rtl/pipelined_alu.sv
// Handshaked ALU: base ops complete at the accept edge; MUL and variable shifts
// iterate one bit per clock in EXEC before presenting the result in DONE.
module pipelined_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  localparam int CNT_W = ((SHAMT_W > $clog2(WIDTH)) ? SHAMT_W : $clog2(WIDTH)) + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [5:0] F_ADD  = 6'd0;
  localparam logic [5:0] F_SUB  = 6'd1;
  localparam logic [5:0] F_AND  = 6'd2;
  localparam logic [5:0] F_ORR  = 6'd3;
  localparam logic [5:0] F_NOT  = 6'd4;
  localparam logic [5:0] F_TCP  = 6'd5;
  localparam logic [5:0] F_SHL  = 6'd6;
  localparam logic [5:0] F_SHR  = 6'd7;
  localparam logic [5:0] F_MUL  = 6'd8;
  localparam logic [5:0] F_SLLV = 6'd9;
  localparam logic [5:0] F_SRAV = 6'd10;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_is_mul;
  logic                  r_is_left;
  logic [2*WIDTH-1:0]    r_acc;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [WIDTH-1:0]      r_sh;
  logic [WIDTH-1:0]      r_result;
  logic                  r_zero;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_last_step;
  logic [WIDTH-1:0]      w_sum;
  logic [WIDTH-1:0]      w_diff;
  logic [WIDTH-1:0]      w_tcp;
  logic [CNT_W-1:0]      w_shamt;
  logic [WIDTH-1:0]      w_sc_result;
  logic                  w_sc_ovf;
  logic                  w_is_iter;
  logic [2*WIDTH-1:0]    w_acc_nxt;
  logic [WIDTH-1:0]      w_sh_nxt;
  logic [WIDTH-1:0]      w_iter_result;
  logic                  w_iter_ovf;

  assign in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_last_step = (r_state == S_EXEC) && (r_cnt == CNT_W'(1));
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_overflow;

  assign w_sum   = data_1 + data_2;
  assign w_diff  = data_1 - data_2;
  assign w_tcp   = ~data_1 + ONE_W;
  assign w_shamt = CNT_W'(data_2[SHAMT_W-1:0]);

  // Single-cycle result, overflow and iterative-op detection for the presented op
  always_comb begin
    w_sc_result = ZERO_W;
    w_sc_ovf    = 1'b0;
    w_is_iter   = 1'b0;
    case (func)
      F_ADD: begin
        w_sc_result = w_sum;
        w_sc_ovf    = (data_1[MSB] == data_2[MSB]) && (w_sum[MSB] != data_1[MSB]);
      end
      F_SUB: begin
        w_sc_result = w_diff;
        w_sc_ovf    = (data_1[MSB] != data_2[MSB]) && (w_diff[MSB] != data_1[MSB]);
      end
      F_AND:  w_sc_result = data_1 & data_2;
      F_ORR:  w_sc_result = data_1 | data_2;
      F_NOT:  w_sc_result = ~data_1;
      F_TCP: begin
        w_sc_result = w_tcp;
        w_sc_ovf    = (data_1 == MIN_NEG);
      end
      F_SHL:  w_sc_result = {data_1[MSB-1:0], 1'b0};
      F_SHR:  w_sc_result = {1'b0, data_1[MSB:1]};
      F_MUL:  w_is_iter   = 1'b1;
      F_SLLV, F_SRAV: begin
        // A zero shift amount completes immediately with A unchanged
        w_sc_result = data_1;
        w_is_iter   = (w_shamt != {CNT_W{1'b0}});
      end
      default: w_sc_result = ZERO_W;
    endcase
  end

  // One iteration step of the multiplier or shifter
  always_comb begin
    w_acc_nxt     = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    w_sh_nxt      = r_is_left ? {r_sh[MSB-1:0], 1'b0} : {r_sh[MSB], r_sh[MSB:1]};
    w_iter_result = r_is_mul ? w_acc_nxt[WIDTH-1:0] : w_sh_nxt;
    w_iter_ovf    = r_is_mul && (w_acc_nxt[2*WIDTH-1:WIDTH] != ZERO_W);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_is_iter ? S_EXEC : S_DONE;
        end else if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers and the registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_is_mul   <= 1'b0;
      r_is_left  <= 1'b0;
      r_acc      <= {(2*WIDTH){1'b0}};
      r_mcand    <= {(2*WIDTH){1'b0}};
      r_mplier   <= ZERO_W;
      r_sh       <= ZERO_W;
      r_result   <= ZERO_W;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_is_iter) begin
        r_is_mul  <= (func == F_MUL);
        r_is_left <= (func == F_SLLV);
        r_cnt     <= (func == F_MUL) ? CNT_W'(WIDTH) : w_shamt;
        r_acc     <= {(2*WIDTH){1'b0}};
        r_mcand   <= {ZERO_W, data_1};
        r_mplier  <= data_2;
        r_sh      <= data_1;
      end else begin
        r_cnt      <= {CNT_W{1'b0}};
        r_result   <= w_sc_result;
        r_zero     <= (w_sc_result == ZERO_W);
        r_overflow <= w_sc_ovf;
      end
    end else if (r_state == S_EXEC) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[MSB:1]};
      r_sh     <= w_sh_nxt;
      if (w_last_step) begin
        r_result   <= w_iter_result;
        r_zero     <= (w_iter_result == ZERO_W);
        r_overflow <= w_iter_ovf;
      end
    end
  end

  pipelined_alu_checker #(.WIDTH(WIDTH)) u_checker (
    .clk       (clk),
    .reset     (reset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

endmodule

// Protocol properties: a stalled result stays put, and zero always tracks result.
module pipelined_alu_checker #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] result,
  input logic             zero
);
  a_hold_stalled: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(result)));

  a_zero_flag: assert property (@(posedge clk) disable iff (reset)
    out_valid |-> (zero == (result == {WIDTH{1'b0}})));
endmodule
